imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the next-generation decode path. Covers all RV32I/RV64I immediate formats (I, S, B, U, J, plus CSR zimm) and sign-extends to XLEN. Sits between instruction fetch/IF-ID and the register-read stage, behind an elastic valid/ready pipeline of STAGES registers with flush. Emits a format code and an illegal-encoding flag alongside each immediate.

---
 rtl/imm_gen_pipe.sv | 131 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator behind an elastic valid/ready pipeline.
// Decode happens before stage 0; the remaining stages only carry the decoded entry.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic            illegal_out,
  output logic [31:0]     instr_out
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [31:0]     instr;
  } ent_t;

  ent_t              dec;
  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] ld;

  always_comb begin
    dec       = '0;
    dec.fmt   = FMT_NONE;
    dec.ill   = 1'b1;
    dec.instr = instr;
    if (instr[1:0] == 2'b11) begin
      dec.ill = 1'b0;
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: dec.fmt = FMT_I;
        OP_IMM32: begin
          if (XLEN == 64) dec.fmt = FMT_I;
          else            dec.ill = 1'b1;
        end
        OP_SYSTEM:         dec.fmt = instr[14] ? FMT_Z : FMT_I;
        OP_STORE:          dec.fmt = FMT_S;
        OP_BRANCH:         dec.fmt = FMT_B;
        OP_LUI, OP_AUIPC:  dec.fmt = FMT_U;
        OP_JAL:            dec.fmt = FMT_J;
        default:           dec.ill = 1'b1;
      endcase
    end
    case (dec.fmt)
      FMT_I:   dec.imm = XLEN'($signed(instr[31:20]));
      FMT_S:   dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:   dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U:   dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J:   dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_Z:   dec.imm = XLEN'(instr[19:15]);
      default: dec.imm = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic v_q, v_d, vin;
      ent_t ent_q, ent_d, ent_in;

      if (gi == 0) begin : g_src
        assign vin    = in_valid;
        assign ent_in = dec;
      end else begin : g_src
        assign vin    = g_stage[gi-1].v_q;
        assign ent_in = g_stage[gi-1].ent_q;
      end

      // A stage can load if it, or any stage downstream of it, has a free slot.
      assign v_vec[gi] = v_q;
      assign ld[gi]    = out_ready || !(&v_vec[STAGES-1:gi]);

      always_comb begin
        v_d   = v_q;
        ent_d = ent_q;
        if (ld[gi]) begin
          v_d = vin;
          if (vin) ent_d = ent_in;
        end
        if (flush) v_d = 1'b0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          ent_q <= '0;
        end else begin
          v_q   <= v_d;
          ent_q <= ent_d;
        end
      end
    end
  endgenerate

  assign in_ready    = ld[0];
  assign out_valid   = v_vec[STAGES-1];
  assign imm_out     = g_stage[STAGES-1].ent_q.imm;
  assign fmt_out     = g_stage[STAGES-1].ent_q.fmt;
  assign illegal_out = g_stage[STAGES-1].ent_q.ill;
  assign instr_out   = g_stage[STAGES-1].ent_q.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (32/1, 64/2, 32/3) checked by
// fixed vectors, hand sequences and a scoreboard against an arithmetic model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  int          sel;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_instr;
  logic [2:0]  a_fmt;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm;
  logic [31:0] b_instr;
  logic [2:0]  b_fmt;
  logic        c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_imm, c_instr;
  logic [2:0]  c_fmt;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 0),
    .in_ready(a_in_ready), .instr(instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm_out(a_imm), .fmt_out(a_fmt), .illegal_out(a_ill), .instr_out(a_instr));
  imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 1),
    .in_ready(b_in_ready), .instr(instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm_out(b_imm), .fmt_out(b_fmt), .illegal_out(b_ill), .instr_out(b_instr));
  imm_gen_pipe #(.XLEN(32), .STAGES(3)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 2),
    .in_ready(c_in_ready), .instr(instr), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm_out(c_imm), .fmt_out(c_fmt), .illegal_out(c_ill), .instr_out(c_instr));

  logic        cur_in_ready, cur_out_valid, cur_ill;
  logic [63:0] cur_imm;
  logic [2:0]  cur_fmt;
  logic [31:0] cur_instr;
  int          cur_xlen;

  always_comb begin
    cur_in_ready = a_in_ready; cur_out_valid = a_out_valid; cur_imm = {32'b0, a_imm};
    cur_fmt = a_fmt; cur_ill = a_ill; cur_instr = a_instr; cur_xlen = 32;
    if (sel == 1) begin
      cur_in_ready = b_in_ready; cur_out_valid = b_out_valid; cur_imm = b_imm;
      cur_fmt = b_fmt; cur_ill = b_ill; cur_instr = b_instr; cur_xlen = 64;
    end else if (sel == 2) begin
      cur_in_ready = c_in_ready; cur_out_valid = c_out_valid; cur_imm = {32'b0, c_imm};
      cur_fmt = c_fmt; cur_ill = c_ill; cur_instr = c_instr;
    end
  end

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t vecs[13];
  logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

  logic        prev_stall = 1'b0, prev_flush = 1'b0;
  logic [63:0] prev_imm, prev_meta;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate value worked out as a signed integer from weighted fields.
  function automatic exp_t model(input logic [31:0] w, input int xlen);
    exp_t       e;
    longint     v;
    logic [6:0] op;
    e.fmt = 3'd0; e.ill = 1'b1; e.instr = w; v = 0; op = w[6:0];
    if (w[1:0] == 2'b11) begin
      e.ill = 1'b0;
      if (op inside {7'h03, 7'h13, 7'h67, 7'h0F} || (op == 7'h1B && xlen == 64) ||
          (op == 7'h73 && !w[14]))      e.fmt = 3'd1;
      else if (op == 7'h73)             e.fmt = 3'd6;
      else if (op == 7'h23)             e.fmt = 3'd2;
      else if (op == 7'h63)             e.fmt = 3'd3;
      else if (op inside {7'h37, 7'h17}) e.fmt = 3'd4;
      else if (op == 7'h6F)             e.fmt = 3'd5;
      else                              e.ill = 1'b1;
    end
    case (e.fmt)
      3'd1: v = longint'(w[31:20]) - 4096 * longint'(w[31]);
      3'd2: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - 4096 * longint'(w[31]);
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                - 4096 * longint'(w[31]);
      3'd4: v = longint'(w[31:12]) * 4096 - (longint'(1) << 32) * longint'(w[31]);
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                - longint'(w[31]) * (longint'(1) << 20);
      3'd6: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    e.imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic mon_step();
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall && !prev_flush) begin
      chk("hold_valid", cur_out_valid, 1);
      chk("hold_imm", cur_imm, prev_imm);
      chk("hold_meta", {cur_fmt, cur_ill, cur_instr}, prev_meta);
    end
    if (cur_out_valid && out_ready) begin
      chk("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_imm", cur_imm, e.imm);
        chk("sb_fmt", cur_fmt, e.fmt);
        chk("sb_ill", cur_ill, e.ill);
        chk("sb_instr", cur_instr, e.instr);
      end
    end
    if (flush) exp_q.delete();
    else if (in_valid && cur_in_ready) exp_q.push_back(model(instr, cur_xlen));
    prev_stall = cur_out_valid && !out_ready;
    prev_flush = flush;
    prev_imm   = cur_imm;
    prev_meta  = {29'b0, cur_fmt, cur_ill, cur_instr};
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", cur_out_valid, 0);
  endtask

  task automatic run_table(input int s);
    vec_t list[$];
    int   lat;
    foreach (vecs[i]) if (vecs[i].sel == s) list.push_back(vecs[i]);
    sel = s; out_ready = 1'b1; lat = s + 1;
    for (int c = 0; c < list.size() + lat; c++) begin
      in_valid = (c < list.size());
      if (c < list.size()) instr = list[c].instr;
      @(negedge clk);
      if (c < list.size()) chk("tbl_in_ready", cur_in_ready, 1);
      if (c >= lat) begin
        chk("tbl_valid", cur_out_valid, 1);
        chk("tbl_imm", cur_imm, list[c-lat].imm);
        chk("tbl_fmt", cur_fmt, list[c-lat].fmt);
        chk("tbl_ill", cur_ill, list[c-lat].ill);
        chk("tbl_instr", cur_instr, list[c-lat].instr);
      end else begin
        chk("tbl_latency", cur_out_valid, 0);
      end
      tick();
    end
    drain();
  endtask

  task automatic run_random(input int s, input int cycles);
    logic hold;
    sel = s; hold = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 9) < 7);
        instr    = rand_instr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      hold = in_valid && !cur_in_ready && !flush;
      tick();
    end
    drain();
  endtask

  logic [31:0] stall_w[5];
  int          idx, emerged;
  logic [31:0] e6;

  initial begin
    vecs[0]  = '{0, 32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 1'b0};
    vecs[1]  = '{0, 32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 1'b0};
    vecs[2]  = '{0, 32'hFE000CE3, 64'hFFFF_FFF8, 3'd3, 1'b0};
    vecs[3]  = '{0, 32'h123450B7, 64'h1234_5000, 3'd4, 1'b0};
    vecs[4]  = '{0, 32'h001000EF, 64'h0000_0800, 3'd5, 1'b0};
    vecs[5]  = '{0, 32'h3002D073, 64'h0000_0005, 3'd6, 1'b0};
    vecs[6]  = '{0, 32'h0000007F, 64'h0, 3'd0, 1'b1};
    vecs[7]  = '{0, 32'h00000090, 64'h0, 3'd0, 1'b1};
    vecs[8]  = '{0, 32'h0010009B, 64'h0, 3'd0, 1'b1};
    vecs[9]  = '{1, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
    vecs[10] = '{1, 32'h0010009B, 64'h1, 3'd1, 1'b0};
    vecs[11] = '{1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
    vecs[12] = '{1, 32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_out_valid", cur_out_valid, 0);
      chk("rst_imm", cur_imm, 0);
      chk("rst_fmt", cur_fmt, 0);
      chk("rst_ill", cur_ill, 0);
      chk("rst_instr", cur_instr, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_in_ready", cur_in_ready, 1);
    end
    tick();

    run_table(0);
    run_table(1);

    // Backpressure: three-deep pipe fills, then drains in order.
    sel = 2; out_ready = 1'b0; idx = 0;
    foreach (stall_w[i]) stall_w[i] = rand_instr();
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      instr    = stall_w[(idx < 5) ? idx : 4];
      @(negedge clk);
      chk("stall_in_ready", cur_in_ready, (c < 3));
      if (c >= 3) begin
        chk("stall_out_valid", cur_out_valid, 1);
        chk("stall_head", cur_instr, stall_w[0]);
      end
      if (in_valid && cur_in_ready) idx++;
      tick();
    end
    chk("stall_accepted", idx, 3);
    out_ready = 1'b1; emerged = 0;
    for (int c = 0; c < 30 && emerged < 5; c++) begin
      in_valid = (idx < 5);
      instr    = stall_w[(idx < 5) ? idx : 4];
      @(negedge clk);
      if (in_valid && cur_in_ready) idx++;
      if (cur_out_valid) emerged++;
      tick();
    end
    chk("stall_emerged", emerged, 5);
    drain();

    // Flush with a full pipe, then flush while a new input is accepted.
    sel = 1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = rand_instr();
      @(negedge clk);
      chk("fl_fill_ready", cur_in_ready, 1);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; instr = rand_instr();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_full_cleared", cur_out_valid, 0);
    tick();
    in_valid = 1'b1; instr = rand_instr();
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; instr = rand_instr();
    @(negedge clk);
    chk("fl_in_ready", cur_in_ready, 1);
    tick();
    flush = 1'b0; e6 = rand_instr(); instr = e6;
    @(negedge clk);
    chk("fl_cleared", cur_out_valid, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_no_ghost", cur_out_valid, 0);
    tick();
    @(negedge clk);
    chk("fl_next_valid", cur_out_valid, 1);
    chk("fl_next_instr", cur_instr, e6);
    tick();
    drain();

    for (int s = 0; s < 3; s++) run_random(s, 400);

    // Asynchronous reset between clock edges while streaming.
    sel = 2; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; instr = rand_instr();
      tick();
    end
    chk("pre_rst_valid", cur_out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", cur_out_valid, 0);
    chk("arst_imm", cur_imm, 0);
    chk("arst_fmt", cur_fmt, 0);
    chk("arst_ill", cur_ill, 0);
    chk("arst_instr", cur_instr, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", cur_in_ready, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instr = rand_instr();
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
